muldiv_ctrl: RTL and testbench

//  Sequencer and HI/LO owner for the multicycle MIPS core's multiply/divide resources.

---
 rtl/muldiv_ctrl.sv | 175 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for the multicycle MIPS core: owns HI/LO, drives the
// Div/Mult start levels, stalls MFHI/MFLO while busy and flags div-by-zero/timeout.
module muldiv_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  output logic         cmd_ready,
  input  logic         rd_req,
  input  logic         rd_sel,
  output logic [W-1:0] rd_data,
  output logic         stall,
  output logic         div_start,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic         div_end,
  input  logic         div_by_zero,
  input  logic [W-1:0] div_hi,
  input  logic [W-1:0] div_lo,
  output logic         mult_start,
  output logic [W-1:0] mult_a,
  output logic [W-1:0] mult_b,
  input  logic         mult_end,
  input  logic [W-1:0] mult_hi,
  input  logic [W-1:0] mult_lo,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         done,
  output logic         exc_div0,
  output logic         exc_timeout
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN_DIV, RUN_MULT, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]   div_a_q, div_a_d, div_b_q, div_b_d;
  logic [W-1:0]   mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic           div_start_q, div_start_d, mult_start_q, mult_start_d;
  logic           done_q, done_d, exc_div0_q, exc_div0_d, exc_to_q, exc_to_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    div_start_d  = div_start_q;
    mult_start_d = mult_start_q;
    done_d       = 1'b0;
    exc_div0_d   = 1'b0;
    exc_to_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'b00: begin
              mult_a_d     = rs_val;
              mult_b_d     = rt_val;
              mult_start_d = 1'b1;
              cnt_d        = '0;
              state_d      = RUN_MULT;
            end
            2'b01: begin
              div_a_d     = rs_val;
              div_b_d     = rt_val;
              div_start_d = 1'b1;
              cnt_d       = '0;
              state_d     = RUN_DIV;
            end
            2'b10:   hi_d = rs_val;
            default: lo_d = rs_val;
          endcase
        end
      end
      RUN_DIV: begin
        // End flag wins over the watchdog when both land on the same edge.
        if (div_end) begin
          div_start_d = 1'b0;
          state_d     = DRAIN;
          if (div_by_zero) begin
            exc_div0_d = 1'b1;
          end else begin
            hi_d   = div_hi;
            lo_d   = div_lo;
            done_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          exc_to_d    = 1'b1;
          div_start_d = 1'b0;
          state_d     = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN_MULT: begin
        if (mult_end) begin
          hi_d         = mult_hi;
          lo_d         = mult_lo;
          done_d       = 1'b1;
          mult_start_d = 1'b0;
          state_d      = DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          exc_to_d     = 1'b1;
          mult_start_d = 1'b0;
          state_d      = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // One cycle with both starts low lets the unit clear its own counter.
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      div_start_q  <= 1'b0;
      mult_start_q <= 1'b0;
      done_q       <= 1'b0;
      exc_div0_q   <= 1'b0;
      exc_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      div_start_q  <= div_start_d;
      mult_start_q <= mult_start_d;
      done_q       <= done_d;
      exc_div0_q   <= exc_div0_d;
      exc_to_q     <= exc_to_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign stall       = rd_req & (state_q != IDLE);
  assign rd_data     = rd_sel ? hi_q : lo_q;
  assign div_start   = div_start_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign mult_start  = mult_start_q;
  assign mult_a      = mult_a_q;
  assign mult_b      = mult_b_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign done        = done_q;
  assign exc_div0    = exc_div0_q;
  assign exc_timeout = exc_to_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural Div (negedge) and Mult units.
module tb_muldiv_ctrl;

  localparam int W       = 32;
  localparam int TIMEOUT = 40;
  localparam int DLAT    = 4;
  localparam int MLAT    = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] rs_val = '0, rt_val = '0;
  logic         cmd_ready, rd_req = 1'b0, rd_sel = 1'b0, stall;
  logic [W-1:0] rd_data;
  logic         div_start, div_end = 1'b0, div_by_zero;
  logic [W-1:0] div_a, div_b, div_hi = '0, div_lo = '0;
  logic         mult_start, mult_end = 1'b0;
  logic [W-1:0] mult_a, mult_b, mult_hi = '0, mult_lo = '0;
  logic [W-1:0] hi, lo;
  logic         done, exc_div0, exc_timeout;

  muldiv_ctrl #(.TIMEOUT(TIMEOUT), .W(W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .rs_val(rs_val), .rt_val(rt_val), .cmd_ready(cmd_ready),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data), .stall(stall),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_end(div_end),
    .div_by_zero(div_by_zero), .div_hi(div_hi), .div_lo(div_lo),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_end(mult_end), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .hi(hi), .lo(lo), .done(done), .exc_div0(exc_div0), .exc_timeout(exc_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural Div unit: updates on negedge, never finishes when div_never is set.
  logic div_never = 1'b0;
  int   dcnt = 0;
  assign div_by_zero = (div_b == '0);
  always @(negedge clk) begin
    if (!div_start) begin
      dcnt = 0;
      div_end <= 1'b0;
    end else if (!div_never) begin
      if (dcnt == DLAT - 1) begin
        div_end <= 1'b1;
        if (div_b != '0) begin
          div_hi <= $signed(div_a) % $signed(div_b);
          div_lo <= $signed(div_a) / $signed(div_b);
        end else begin
          div_hi <= 32'hDEAD_BEEF;
          div_lo <= 32'hDEAD_BEEF;
        end
      end else begin
        dcnt++;
      end
    end
  end

  int mcnt = 0;
  logic signed [63:0] prod;
  always @(negedge clk) begin
    if (!mult_start) begin
      mcnt = 0;
      mult_end <= 1'b0;
    end else if (mcnt == MLAT - 1) begin
      prod = $signed(mult_a) * $signed(mult_b);
      mult_end <= 1'b1;
      mult_hi  <= prod[63:32];
      mult_lo  <= prod[31:0];
    end else begin
      mcnt++;
    end
  end

  typedef struct {
    logic [2:0]   kind;   // {done, exc_div0, exc_timeout}
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } ev_t;
  ev_t exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (done | exc_div0 | exc_timeout) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got kind %b expected none", {done, exc_div0, exc_timeout});
      end else begin
        e = exp_q.pop_front();
        chk("ev_kind", {29'b0, done, exc_div0, exc_timeout}, {29'b0, e.kind});
        chk("ev_hi", hi, e.hi);
        chk("ev_lo", lo, e.lo);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("issue_ready", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    rs_val    = a;
    rt_val    = b;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_ev(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(done | exc_div0 | exc_timeout) && n < 200);
    if (!(done | exc_div0 | exc_timeout)) chk("event_wait", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_starts", {30'b0, div_start, mult_start}, 32'd0);
    reset = 1'b1;

    // DIV 100 / 7
    exp_q.push_back('{3'b100, 32'd2, 32'd14});
    issue(2'b01, 32'd100, 32'd7);
    chk("div1_start", {31'b0, div_start}, 32'd1);
    chk("div1_a", div_a, 32'd100);
    chk("div1_b", div_b, 32'd7);
    chk("div1_busy", {31'b0, cmd_ready}, 32'd0);
    rs_val = 32'h1234;
    rt_val = 32'd0;
    wait_ev(n);
    chk("div1_lat", n, DLAT);
    chk("div1_start_drop", {31'b0, div_start}, 32'd0);
    chk("div1_drain_busy", {31'b0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("div1_ready_back", {31'b0, cmd_ready}, 32'd1);

    // DIV -100 / 7 with MFLO stalled mid-operation
    exp_q.push_back('{3'b100, 32'hFFFF_FFFE, 32'hFFFF_FFF2});
    issue(2'b01, 32'hFFFF_FF9C, 32'd7);
    rd_req = 1'b1;
    rd_sel = 1'b0;
    #1 chk("div2_stall", {31'b0, stall}, 32'd1);
    wait_ev(n);
    chk("div2_stall_drain", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    chk("div2_stall_rel", {31'b0, stall}, 32'd0);
    chk("div2_mflo", rd_data, 32'hFFFF_FFF2);
    rd_sel = 1'b1;
    #1 chk("div2_mfhi", rd_data, 32'hFFFF_FFFE);

    // MTHI with simultaneous read returns the old HI
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    rs_val    = 32'd5;
    #1 chk("mthi_old_read", rd_data, 32'hFFFF_FFFE);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    rd_req = 1'b0;
    chk("mthi_hi", hi, 32'd5);
    chk("mthi_ready", {31'b0, cmd_ready}, 32'd1);
    issue(2'b11, 32'd5, 32'd0);
    chk("mtlo_lo", lo, 32'd5);

    // DIV by zero leaves HI/LO intact
    exp_q.push_back('{3'b010, 32'd5, 32'd5});
    issue(2'b01, 32'd9, 32'd0);
    wait_ev(n);
    chk("div0_hi", hi, 32'd5);
    chk("div0_lo", lo, 32'd5);

    // MULT 0xFFFFFFFF * 2 (signed -1 * 2)
    exp_q.push_back('{3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    issue(2'b00, 32'hFFFF_FFFF, 32'd2);
    chk("mult_start", {30'b0, div_start, mult_start}, 32'd1);
    chk("mult_a", mult_a, 32'hFFFF_FFFF);
    chk("mult_b", mult_b, 32'd2);
    wait_ev(n);
    chk("mult_lat", n, MLAT);

    // Watchdog: Div never finishes
    div_never = 1'b1;
    exp_q.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    issue(2'b01, 32'd1, 32'd1);
    wait_ev(n);
    chk("to_cycles", n, TIMEOUT);
    chk("to_start_drop", {31'b0, div_start}, 32'd0);

    // Reset on cycle 10 of a DIV
    issue(2'b01, 32'd3, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("mrst_start", {31'b0, div_start}, 32'd0);
    chk("mrst_hi", hi, 32'd0);
    chk("mrst_lo", lo, 32'd0);
    chk("mrst_div_a", div_a, 32'd0);
    chk("mrst_pulses", {29'b0, done, exc_div0, exc_timeout}, 32'd0);
    reset = 1'b1;
    div_never = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("exp_q_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
